// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, CRC16 constants,
// packetizer state encoding and the byte-serial CRC16 step.
package usb_pkg;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  localparam logic [15:0] CRC16_POLY = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    FILL_RD,
    FILL_CAP,
    SEND_PID,
    SEND_DATA,
    SEND_CRC_L,
    SEND_CRC_H,
    WAIT_HS
  } pkt_state_e;

  // Reflected CRC16, LSB of the data byte first.
  function automatic logic [15:0] crc16_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      if (r[0]) r = (r >> 1) ^ CRC16_POLY;
      else      r = r >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-serial USB CRC16 accumulator.
// init reloads the seed and wins over en.
module usb_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_nxt;

  always_comb begin
    crc_nxt = crc16_byte(crc, data);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= CRC16_INIT;
    end else if (init) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc_nxt;
    end
  end

endmodule

// File: rtl/usb_in_packetizer.sv
// Bulk IN endpoint packetizer: fills a retry buffer from the
// byte queue and answers IN tokens with NAK or a DATAx packet.
module usb_in_packetizer
  import usb_pkg::*;
#(
  parameter int MAX_PKT = 64,
  parameter bit ZLP_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       q_empty,
  input  logic [7:0] q_data,
  output logic       q_rd,
  input  logic       in_token,
  output logic       nak,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       tx_last,
  input  logic       tx_ready,
  input  logic       ack_rcvd,
  input  logic       hs_timeout,
  output logic       busy
);

  localparam int AW =
    (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
  localparam logic [6:0] MAX_CNT = 7'(MAX_PKT);

  pkt_state_e  state;
  pkt_state_e  state_nxt;

  logic [6:0]  buf_cnt;
  logic [6:0]  len;
  logic [6:0]  idx;
  logic        toggle;
  logic        locked;
  logic        zlp_owed;
  logic        pending_tok;

  logic [7:0]  buf_mem [MAX_PKT];
  logic [15:0] crc;

  logic        tok;
  logic        nak_cond;
  logic        can_fill;
  logic        crc_init;
  logic        crc_en;

  usb_crc16 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .data (tx_data),
    .crc  (crc)
  );

  always_comb begin
    tok       = in_token | pending_tok;
    nak_cond  = (buf_cnt == 7'd0) && !zlp_owed
              && !locked;
    can_fill  = !locked && !q_empty
              && (buf_cnt < MAX_CNT);
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_last   = 1'b0;
    tx_data   = 8'h00;
    crc_init  = 1'b0;
    crc_en    = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (tok) begin
          if (!nak_cond) state_nxt = SEND_PID;
        end else if (can_fill) begin
          state_nxt = FILL_RD;
        end
      end
      FILL_RD:  state_nxt = FILL_CAP;
      FILL_CAP: state_nxt = IDLE;
      SEND_PID: begin
        tx_valid = 1'b1;
        tx_data  = toggle ? PID_DATA1 : PID_DATA0;
        crc_init = 1'b1;
        if (tx_ready) begin
          if (len == 7'd0) state_nxt = SEND_CRC_L;
          else             state_nxt = SEND_DATA;
        end
      end
      SEND_DATA: begin
        tx_valid = 1'b1;
        tx_data  = buf_mem[idx[AW-1:0]];
        crc_en   = tx_ready;
        if (tx_ready && (idx == len - 7'd1))
          state_nxt = SEND_CRC_L;
      end
      SEND_CRC_L: begin
        tx_valid = 1'b1;
        tx_data  = ~crc[7:0];
        if (tx_ready) state_nxt = SEND_CRC_H;
      end
      SEND_CRC_H: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = ~crc[15:8];
        if (tx_ready) state_nxt = WAIT_HS;
      end
      WAIT_HS: begin
        if (ack_rcvd || hs_timeout)
          state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      buf_cnt     <= 7'd0;
      len         <= 7'd0;
      idx         <= 7'd0;
      toggle      <= 1'b0;
      locked      <= 1'b0;
      zlp_owed    <= 1'b0;
      pending_tok <= 1'b0;
      q_rd        <= 1'b0;
      nak         <= 1'b0;
    end else begin
      state <= state_nxt;
      q_rd  <= (state_nxt == FILL_RD);
      nak   <= (state == IDLE) && tok && nak_cond;
      unique case (state)
        IDLE: begin
          if (tok) begin
            pending_tok <= 1'b0;
            if (!nak_cond) begin
              locked <= 1'b1;
              len    <= buf_cnt;
            end
          end
        end
        FILL_RD: begin
          if (in_token) pending_tok <= 1'b1;
        end
        FILL_CAP: begin
          if (in_token) pending_tok <= 1'b1;
          if (buf_cnt < MAX_CNT)
            buf_cnt <= buf_cnt + 7'd1;
        end
        SEND_PID: idx <= 7'd0;
        SEND_DATA: begin
          if (tx_ready) idx <= idx + 7'd1;
        end
        WAIT_HS: begin
          // Timeout keeps everything for a retransmit.
          if (ack_rcvd) begin
            toggle   <= ~toggle;
            buf_cnt  <= 7'd0;
            locked   <= 1'b0;
            zlp_owed <= ZLP_EN && (len == MAX_CNT)
                        && q_empty;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == FILL_CAP) && (buf_cnt < MAX_CNT))
      buf_mem[buf_cnt[AW-1:0]] <= q_data;
  end

endmodule

// File: tb/tb_usb_in_packetizer.sv
// Directed bench for usb_in_packetizer with a queue
// model, a transmit monitor and a bitwise CRC16 model.
module tb_usb_in_packetizer;

  logic       clk = 1'b0;
  logic       rst;
  logic       q_empty;
  logic [7:0] q_data = 8'h00;
  logic       q_rd;
  logic       in_token;
  logic       nak;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       ack_rcvd;
  logic       hs_timeout;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] qmem [0:511];
  int head = 0;
  int tail = 0;

  logic [7:0] rx_d [0:1023];
  logic       rx_l [0:1023];
  int rx_n       = 0;
  int last_cnt   = 0;
  int nak_cnt    = 0;
  int rd_viol    = 0;
  int under_viol = 0;
  int stall_viol = 0;
  logic rd_prev    = 1'b0;
  logic stall_prev = 1'b0;
  logic [7:0] held = 8'h00;

  logic [7:0] dat_q [$];

  assign q_empty = (head == tail);

  always #5 clk = ~clk;

  usb_in_packetizer #(
    .MAX_PKT (64),
    .ZLP_EN  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .q_empty    (q_empty),
    .q_data     (q_data),
    .q_rd       (q_rd),
    .in_token   (in_token),
    .nak        (nak),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .ack_rcvd   (ack_rcvd),
    .hs_timeout (hs_timeout),
    .busy       (busy)
  );

  always @(negedge clk) begin
    if (q_rd) begin
      if (head == tail) begin
        under_viol <= under_viol + 1;
      end else begin
        q_data <= qmem[head];
        head   <= head + 1;
      end
    end
    if (q_rd && rd_prev) rd_viol <= rd_viol + 1;
    rd_prev <= q_rd;
    if (nak) nak_cnt <= nak_cnt + 1;
    if (tx_valid && tx_ready) begin
      rx_d[rx_n] <= tx_data;
      rx_l[rx_n] <= tx_last;
      rx_n       <= rx_n + 1;
      if (tx_last) last_cnt <= last_cnt + 1;
    end
    if (stall_prev && rst
        && (!tx_valid || tx_data != held))
      stall_viol <= stall_viol + 1;
    stall_prev <= tx_valid && !tx_ready;
    held       <= tx_data;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_token();
    in_token = 1'b1;
    tick();
    in_token = 1'b0;
  endtask

  task automatic pulse_ack();
    ack_rcvd = 1'b1;
    tick();
    ack_rcvd = 1'b0;
    tick();
  endtask

  task automatic load(
    input int         n,
    input logic [7:0] seed,
    input logic [7:0] step
  );
    logic [7:0] v;
    dat_q.delete();
    for (int i = 0; i < n; i++) begin
      v = seed + step * 8'(i);
      dat_q.push_back(v);
      qmem[tail] = v;
      tail++;
    end
  endtask

  function automatic logic [15:0] model_crc();
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (dat_q[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ dat_q[k][b];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'hA001;
      end
    end
    return ~c;
  endfunction

  task automatic wait_last(
    input string tag,
    input bit    rnd
  );
    int l0;
    bit ok;
    l0 = last_cnt;
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      tick();
      if (last_cnt != l0) ok = 1'b1;
    end
    tx_ready = 1'b1;
    check({tag, "_done"}, 32'(ok), 32'd1);
  endtask

  task automatic send_pkt(
    input string      tag,
    input logic [7:0] pid,
    input bit         rnd
  );
    int          start;
    int          n;
    logic [7:0]  exp_b [$];
    logic [15:0] c;
    start = rx_n;
    pulse_token();
    wait_last(tag, rnd);
    c = model_crc();
    exp_b.push_back(pid);
    foreach (dat_q[k]) exp_b.push_back(dat_q[k]);
    exp_b.push_back(c[7:0]);
    exp_b.push_back(c[15:8]);
    n = exp_b.size();
    check({tag, "_len"}, 32'(rx_n - start), 32'(n));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_b%0d", tag, i),
            32'(rx_d[start + i]), 32'(exp_b[i]));
      check($sformatf("%s_l%0d", tag, i),
            32'(rx_l[start + i]), 32'(i == n - 1));
    end
  endtask

  initial begin
    int nak_exp;
    int l0;
    rst        = 1'b0;
    in_token   = 1'b0;
    tx_ready   = 1'b0;
    ack_rcvd   = 1'b0;
    hs_timeout = 1'b0;
    #1;
    check("rst_q_rd",    32'(q_rd),     32'd0);
    check("rst_nak",     32'(nak),      32'd0);
    check("rst_valid",   32'(tx_valid), 32'd0);
    check("rst_last",    32'(tx_last),  32'd0);
    check("rst_data",    32'(tx_data),  32'd0);
    check("rst_busy",    32'(busy),     32'd0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();

    // empty queue -> single-cycle nak, no data
    nak_exp = 1;
    pulse_token();
    repeat (5) tick();
    check("nak_empty", 32'(nak_cnt), 32'(nak_exp));
    check("nak_no_tx", 32'(rx_n), 32'd0);

    // four bytes, DATA0, then timeout and retransmit
    load(4, 8'h00, 8'h01);
    repeat (20) tick();
    tx_ready = 1'b1;
    send_pkt("p4", 8'hC3, 1'b0);
    check("p4_busy_hs", 32'(busy), 32'd1);
    hs_timeout = 1'b1;
    tick();
    hs_timeout = 1'b0;
    tick();
    check("p4_idle", 32'(busy), 32'd0);
    send_pkt("p4_retx", 8'hC3, 1'b0);
    pulse_ack();

    load(1, 8'hA5, 8'h00);
    repeat (10) tick();
    send_pkt("p1", 8'h4B, 1'b0);
    pulse_ack();

    // full packet followed by a zero-length packet
    load(64, 8'h40, 8'h07);
    repeat (220) tick();
    send_pkt("p64", 8'hC3, 1'b0);
    pulse_ack();
    dat_q.delete();
    send_pkt("zlp", 8'h4B, 1'b0);
    pulse_ack();
    l0 = rx_n;
    nak_exp++;
    pulse_token();
    repeat (5) tick();
    check("nak_after_zlp", 32'(nak_cnt), 32'(nak_exp));
    check("nak_zlp_no_tx", 32'(rx_n - l0), 32'd0);

    // random backpressure
    load(10, 8'hF0, 8'h13);
    repeat (40) tick();
    send_pkt("p10", 8'hC3, 1'b1);
    pulse_ack();
    check("stall_stable", 32'(stall_viol), 32'd0);

    // reset in the middle of the payload
    load(10, 8'h21, 8'h05);
    repeat (40) tick();
    tx_ready = 1'b0;
    pulse_token();
    repeat (3) tick();
    tx_ready = 1'b1;
    repeat (2) tick();
    tx_ready = 1'b0;
    check("mid_valid", 32'(tx_valid), 32'd1);
    l0 = last_cnt;
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(tx_valid), 32'd0);
    check("arst_last",  32'(tx_last),  32'd0);
    check("arst_data",  32'(tx_data),  32'd0);
    check("arst_q_rd",  32'(q_rd),     32'd0);
    check("arst_nak",   32'(nak),      32'd0);
    check("arst_busy",  32'(busy),     32'd0);
    repeat (2) tick();
    rst = 1'b1;
    tx_ready = 1'b1;
    tick();
    check("arst_no_last", 32'(last_cnt), 32'(l0));
    nak_exp++;
    pulse_token();
    repeat (5) tick();
    check("arst_nak_pulse", 32'(nak_cnt), 32'(nak_exp));
    load(1, 8'h11, 8'h00);
    repeat (10) tick();
    send_pkt("post_rst", 8'hC3, 1'b0);
    pulse_ack();

    check("q_rd_gap",   32'(rd_viol),    32'd0);
    check("q_rd_empty", 32'(under_viol), 32'd0);
    check("q_drained",  32'(head),       32'(tail));

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/usb_in_packetizer.md
Name: usb_in_packetizer

Overview:
Downstream consumer of the byte queue. It drains queue bytes into a MAX_PKT-byte retry buffer and answers host IN tokens for the bulk IN endpoint. For each token it either signals NAK or streams PID + payload + CRC16 to the SIE transmitter. It holds the buffer until the host ACKs, and retransmits it with the same PID on timeout.

Parameters:
MAX_PKT, 64, max payload bytes per packet (1..64)
ZLP_EN, 1, send a zero-length packet after a full packet when the queue is then empty

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
q_empty  in  1  queue empty flag
q_data  in  8  queue read data
q_rd  out  1  queue read strobe (registered, one-cycle pulse)
in_token  in  1  one-cycle pulse: IN token for this endpoint
nak  out  1  one-cycle pulse: SIE must send NAK
tx_valid  out  1  byte on tx_data valid
tx_data  out  8  PID/payload/CRC byte
tx_last  out  1  marks final CRC byte
tx_ready  in  1  SIE accepts byte when tx_valid && tx_ready
ack_rcvd  in  1  one-cycle pulse: host ACK
hs_timeout  in  1  one-cycle pulse: no handshake within timeout
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=0): state IDLE, buf_cnt=0, toggle=DATA0, locked=0, zlp_owed=0; q_rd, nak, tx_valid, tx_last, tx_data all 0.
- Queue read protocol: the queue is edge-detecting. q_rd is held high for exactly 1 cycle, then low for at least 1 cycle. q_data is captured 2 cycles after q_rd rises. Maximum rate is 1 byte per 2 cycles. q_rd is issued only when q_empty=0 was sampled in a cycle with no read outstanding.
- States: IDLE, FILL_RD, FILL_CAP, SEND_PID, SEND_DATA, SEND_CRC_L, SEND_CRC_H, WAIT_HS.
- IDLE:
  - in_token has priority over filling.
  - If !locked && !q_empty && buf_cnt<MAX_PKT, go to FILL_RD.
- FILL_RD: pulse q_rd, go to FILL_CAP.
- FILL_CAP: write q_data to buf[buf_cnt], buf_cnt++, return to IDLE.
- Token while a fill is in flight: the fill completes first (at most 2 cycles), then the token is serviced. The token is latched as pending_tok, never dropped.
- Token service:
  - If buf_cnt==0 && !zlp_owed && !locked: pulse nak 1 cycle, stay IDLE.
  - Otherwise: locked=1, freeze len=buf_cnt, go to SEND_PID.
- SEND_PID: tx_data = 0xC3 (DATA0) or 0x4B (DATA1). CRC initialised to 0xFFFF.
- SEND_DATA: bytes buf[0..len-1] in order, each folded into the CRC when accepted. Skipped if len==0.
- SEND_CRC_L / SEND_CRC_H: send ~crc[7:0], then ~crc[15:8]; tx_last=1 on the high byte.
- Transmit handshake: tx_valid is held with tx_data stable until tx_ready. There are no bubbles between bytes while tx_ready=1.
- WAIT_HS exits:
  - ack_rcvd: toggle flips, buf_cnt=0, locked=0, zlp_owed = ZLP_EN && len==MAX_PKT && q_empty; go to IDLE.
  - hs_timeout: buffer and toggle unchanged, locked stays 1; go to IDLE. The next token retransmits identical bytes.
  - ack_rcvd and hs_timeout in the same cycle: ack wins.
- A ZLP is sent as PID, 0x00, 0x00. zlp_owed clears on its ACK.
- Any token arriving in a SEND_* state or WAIT_HS is ignored.
- Reset mid-packet aborts immediately; no tx_last is produced.
- CRC16 (USB): reflected poly 0xA001, init 0xFFFF, final output inverted, low byte sent first.
- Widths: buf_cnt is 7 bits and saturates at MAX_PKT. Buffer indices wrap never (bounded by len).

Decomposition:
- Shared package usb_pkg:
  - PID constants (PID_DATA0=0xC3, PID_DATA1=0x4B, NAK/ACK codes)
  - CRC16_POLY=0xA001, CRC16_INIT=0xFFFF
  - packetizer state enum
- One sub-module: usb_crc16, byte-serial, combinational next-CRC from (crc_in, data) with registered state, plus init and enable inputs. The same block is reusable by the OUT receiver.

Test Plan:
- Empty queue, in_token -> nak pulses exactly 1 cycle; tx_valid stays 0.
- Queue holds 4 bytes 0x00..0x03, token, tx_ready=1 -> stream C3,00,01,02,03,crcL,crcH. tx_last only on crcH; CRC matches the bench model; q_rd pulses separated by at least 1 low cycle.
- Same packet, hs_timeout, token again -> byte-identical retransmit with PID 0xC3. Then ack_rcvd, then 1 more byte queued, token -> PID 0x4B.
- Queue holds exactly 64 bytes (MAX_PKT=64, ZLP_EN=1), token, ack, token -> second packet is 4B,00,00 with tx_last on the last byte. A third token -> nak.
- tx_ready toggled randomly during a 10-byte packet -> tx_data stable while tx_valid && !tx_ready; no byte lost or duplicated.
- rst asserted mid-SEND_DATA -> all outputs 0 asynchronously; after release, toggle=DATA0, buf_cnt=0, and the next token with an empty queue gives nak.
